// File: rtl/seq_alu_pkg.sv
// Shared opcodes and FSM state type for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_SHL  = 4'b0011;
    localparam logic [3:0] OP_SHR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_NAND = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1000;
    localparam logic [3:0] OP_SHL1 = 4'b1001;
    localparam logic [3:0] OP_SHR1 = 4'b1010;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/strobe/result bundle between the sequencer and the ALU.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               load1;
    logic               load2;
    logic [3:0]         op_code;
    logic               run;
    logic [2*WIDTH-1:0] c;
    logic               zero;
    logic               err;
    logic               busy;
    logic               done;

    modport master (
        output a, b, load1, load2, op_code, run,
        input  c, zero, err, busy, done
    );

    modport slave (
        input  a, b, load1, load2, op_code, run,
        output c, zero, err, busy, done
    );
endinterface

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier: one partial-product step per clock, WIDTH steps.
// product_c/valid_c present the final sum combinationally in the cycle of
// the last step so the caller can register it on that same edge.
module seq_alu_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product_c,
    output logic               busy,
    output logic               valid_c
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [W2-1:0]    partial_q, partial_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic [W2-1:0]    sum_c;
    logic             last_c;

    // Iteration registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            partial_q <= partial_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
        end
    end

    // Load on start, otherwise accumulate and shift while busy.
    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        partial_d = partial_q;
        count_d   = count_q;
        busy_d    = busy_q;
        sum_c     = partial_q + (mplier_q[0] ? mcand_q : '0);
        last_c    = busy_q && (count_q == CW'(WIDTH - 1));

        if (!busy_q) begin
            if (start) begin
                mcand_d   = W2'(a);
                mplier_d  = b;
                partial_d = '0;
                count_d   = '0;
                busy_d    = 1'b1;
            end
        end else begin
            partial_d = sum_c;
            mcand_d   = mcand_q << 1;
            mplier_d  = mplier_q >> 1;
            count_d   = count_q + CW'(1);
            if (last_c) begin
                busy_d = 1'b0;
            end
        end
    end

    assign product_c = sum_c;
    assign valid_c   = last_c;
    assign busy      = busy_q;

endmodule

// File: rtl/seq_alu.sv
// Clocked two-operand ALU: strobed operand registers, single-cycle ops,
// multi-cycle multiply, registered result with zero/err/done flags.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    seq_alu_if.slave   bus
);
    import seq_alu_pkg::*;

    localparam int unsigned W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [W2-1:0]    c_q, c_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [W2-1:0]    alu_c;
    logic             alu_err;
    logic [WIDTH-1:0] nand_w;
    logic [WIDTH-1:0] nor_w;
    logic [WIDTH:0]   shl1_w;

    logic             mul_start_c;
    logic [W2-1:0]    mul_product_c;
    logic             mul_valid_c;
    logic             mul_busy;

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start     (mul_start_c),
        .a         (a_q),
        .b         (b_q),
        .product_c (mul_product_c),
        .busy      (mul_busy),
        .valid_c   (mul_valid_c)
    );

    // Single-cycle datapath; every defined result fits in 2*WIDTH bits.
    always_comb begin
        alu_c   = '0;
        alu_err = 1'b0;
        nand_w  = ~(a_q & b_q);
        nor_w   = ~(a_q | b_q);
        shl1_w  = {a_q, 1'b0};
        case (bus.op_code)
            OP_ADD:  alu_c = W2'(a_q) + W2'(b_q);
            OP_XOR:  alu_c = W2'(a_q ^ b_q);
            OP_SHL:  alu_c = (32'(b_q) >= 32'(W2)) ? '0 : (W2'(a_q) << b_q);
            OP_SHR:  alu_c = (32'(b_q) >= 32'(WIDTH)) ? '0 : W2'(a_q >> b_q);
            OP_AND:  alu_c = W2'(a_q & b_q);
            OP_OR:   alu_c = W2'(a_q | b_q);
            OP_NAND: alu_c = W2'(nand_w);
            OP_NOR:  alu_c = W2'(nor_w);
            OP_SHL1: alu_c = W2'(shl1_w);
            OP_SHR1: alu_c = W2'(a_q >> 1);
            OP_MUL:  alu_c = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next state: loads and runs accepted only in IDLE; MUL waits for the engine.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        zero_d      = zero_q;
        err_d       = err_q;
        done_d      = 1'b0;
        mul_start_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.load1) begin
                    a_d = bus.a;
                end
                if (bus.load2) begin
                    b_d = bus.b;
                end
                if (bus.run) begin
                    if (bus.op_code == OP_MUL) begin
                        mul_start_c = 1'b1;
                        state_d     = MUL;
                    end else begin
                        c_d    = alu_c;
                        zero_d = (alu_c == '0);
                        err_d  = alu_err;
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_valid_c) begin
                    c_d     = mul_product_c;
                    zero_d  = (mul_product_c == '0);
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.c    = c_q;
    assign bus.zero = zero_q;
    assign bus.err  = err_q;
    assign bus.done = done_q;
    assign bus.busy = mul_busy;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8 (vector table + corner sequences)
// and WIDTH=3 (legacy-width multiply/OR).
module tb_seq_alu;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    seq_alu_if #(.WIDTH(8)) bus8 ();
    seq_alu_if #(.WIDTH(3)) bus3 ();

    seq_alu #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    seq_alu #(.WIDTH(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  op;
        logic [15:0] c;
        logic        zero;
        logic        err;
        int          lat;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] a, input logic [7:0] b);
        bus8.a = a;
        bus8.b = b;
        bus8.load1 = 1'b1;
        bus8.load2 = 1'b1;
        tick();
        bus8.load1 = 1'b0;
        bus8.load2 = 1'b0;
    endtask

    // Strobe run for one edge, then wait (bounded) for done; report latency
    // in edges counted from the run edge and number of busy-high cycles.
    task automatic run8(input logic [3:0] op, output int lat, output int bcnt);
        bus8.op_code = op;
        bus8.run = 1'b1;
        tick();
        bus8.run = 1'b0;
        lat = 1;
        bcnt = bus8.busy ? 1 : 0;
        while (!bus8.done && lat < 40) begin
            tick();
            lat++;
            if (bus8.busy) bcnt++;
        end
        chk("done_seen", 32'(bus8.done), 32'd1);
    endtask

    initial begin
        int lat;
        int bcnt;
        checks = 0;
        errors = 0;

        vecs[0]  = '{8'd200, 8'd100, 4'b0000, 16'd300,   1'b0, 1'b0, 1};
        vecs[1]  = '{8'd0,   8'd0,   4'b0000, 16'd0,     1'b1, 1'b0, 1};
        vecs[2]  = '{8'd255, 8'd255, 4'b0000, 16'd510,   1'b0, 1'b0, 1};
        vecs[3]  = '{8'hAA,  8'h0F,  4'b0001, 16'h00A5,  1'b0, 1'b0, 1};
        vecs[4]  = '{8'd255, 8'd255, 4'b0010, 16'd65025, 1'b0, 1'b0, 9};
        vecs[5]  = '{8'h81,  8'h00,  4'b1001, 16'h0102,  1'b0, 1'b0, 1};
        vecs[6]  = '{8'h81,  8'd3,   4'b0011, 16'h0408,  1'b0, 1'b0, 1};
        vecs[7]  = '{8'h81,  8'd9,   4'b0100, 16'h0000,  1'b1, 1'b0, 1};
        vecs[8]  = '{8'h01,  8'd16,  4'b0011, 16'h0000,  1'b1, 1'b0, 1};
        vecs[9]  = '{8'hFF,  8'd15,  4'b0011, 16'h8000,  1'b0, 1'b0, 1};
        vecs[10] = '{8'h81,  8'd7,   4'b0100, 16'h0001,  1'b0, 1'b0, 1};
        vecs[11] = '{8'h81,  8'd0,   4'b1010, 16'h0040,  1'b0, 1'b0, 1};
        vecs[12] = '{8'hF0,  8'h0F,  4'b0110, 16'h00FF,  1'b0, 1'b0, 1};
        vecs[13] = '{8'hF0,  8'h3C,  4'b0111, 16'h00CF,  1'b0, 1'b0, 1};
        vecs[14] = '{8'hF0,  8'h3C,  4'b1000, 16'h0003,  1'b0, 1'b0, 1};
        vecs[15] = '{8'h05,  8'h00,  4'b1101, 16'h0000,  1'b1, 1'b1, 1};
        vecs[16] = '{8'hF0,  8'h3C,  4'b0101, 16'h0030,  1'b0, 1'b0, 1};
        vecs[17] = '{8'd0,   8'd5,   4'b0010, 16'd0,     1'b1, 1'b0, 9};
        vecs[18] = '{8'd13,  8'd11,  4'b0010, 16'd143,   1'b0, 1'b0, 9};

        reset = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.load1 = 1'b0; bus8.load2 = 1'b0;
        bus8.op_code = '0; bus8.run = 1'b0;
        bus3.a = '0; bus3.b = '0; bus3.load1 = 1'b0; bus3.load2 = 1'b0;
        bus3.op_code = '0; bus3.run = 1'b0;
        tick();
        tick();

        chk("rst_c",    32'(bus8.c),    32'd0);
        chk("rst_zero", 32'(bus8.zero), 32'd1);
        chk("rst_err",  32'(bus8.err),  32'd0);
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst3_c",   32'(bus3.c),    32'd0);

        reset = 1'b1;
        tick();

        // Vector table at WIDTH=8.
        for (int i = 0; i < NVEC; i++) begin
            load8(vecs[i].a, vecs[i].b);
            run8(vecs[i].op, lat, bcnt);
            chk($sformatf("v%0d_c", i),    32'(bus8.c),    32'(vecs[i].c));
            chk($sformatf("v%0d_zero", i), 32'(bus8.zero), 32'(vecs[i].zero));
            chk($sformatf("v%0d_err", i),  32'(bus8.err),  32'(vecs[i].err));
            chk($sformatf("v%0d_lat", i),  32'(lat),       32'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i), 32'(bcnt),      (vecs[i].lat == 9) ? 32'd8 : 32'd0);
            tick();
            chk($sformatf("v%0d_pulse", i), 32'(bus8.done), 32'd0);
            chk($sformatf("v%0d_hold", i),  32'(bus8.c),    32'(vecs[i].c));
        end

        // WIDTH=3 legacy: 5*2 takes 4 edges, then OR in 1 edge.
        bus3.a = 3'd5; bus3.b = 3'd2; bus3.load1 = 1'b1; bus3.load2 = 1'b1;
        tick();
        bus3.load1 = 1'b0; bus3.load2 = 1'b0;
        bus3.op_code = 4'b0010; bus3.run = 1'b1;
        tick();
        bus3.run = 1'b0;
        lat = 1;
        while (!bus3.done && lat < 40) begin
            tick();
            lat++;
        end
        chk("w3_mul_lat", 32'(lat),    32'd4);
        chk("w3_mul_c",   32'(bus3.c), 32'd10);
        tick();
        bus3.op_code = 4'b0110; bus3.run = 1'b1;
        tick();
        bus3.run = 1'b0;
        chk("w3_or_done", 32'(bus3.done), 32'd1);
        chk("w3_or_c",    32'(bus3.c),    32'd7);

        // Load and run on the same edge: run sees the old A.
        load8(8'd7, 8'd6);
        bus8.a = 8'd1; bus8.load1 = 1'b1;
        bus8.op_code = 4'b0000; bus8.run = 1'b1;
        tick();
        bus8.load1 = 1'b0; bus8.run = 1'b0;
        chk("ldrun_old", 32'(bus8.c), 32'd13);
        run8(4'b0000, lat, bcnt);
        chk("ldrun_new", 32'(bus8.c), 32'd7);

        // Run and load1 during a multiply are ignored.
        load8(8'd7, 8'd6);
        bus8.op_code = 4'b0010; bus8.run = 1'b1;
        tick();
        bus8.run = 1'b0;
        tick();
        tick();
        bus8.op_code = 4'b0000; bus8.run = 1'b1;
        bus8.a = 8'd1; bus8.load1 = 1'b1;
        tick();
        bus8.run = 1'b0; bus8.load1 = 1'b0;
        lat = 4;
        while (!bus8.done && lat < 40) begin
            tick();
            lat++;
        end
        chk("busy_ign_lat", 32'(lat),    32'd9);
        chk("busy_ign_c",   32'(bus8.c), 32'd42);
        tick();
        chk("busy_ign_noq", 32'(bus8.done), 32'd0);
        run8(4'b0000, lat, bcnt);
        chk("busy_ign_a", 32'(bus8.c), 32'd13);

        // Reset during multiply aborts with no done.
        load8(8'd9, 8'd9);
        bus8.op_code = 4'b0010; bus8.run = 1'b1;
        tick();
        bus8.run = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("abort_busy_pre", 32'(bus8.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_c",    32'(bus8.c),    32'd0);
        chk("abort_zero", 32'(bus8.zero), 32'd1);
        chk("abort_busy", 32'(bus8.busy), 32'd0);
        chk("abort_done", 32'(bus8.done), 32'd0);
        tick();
        chk("abort_done2", 32'(bus8.done), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("abort_nodone", 32'(bus8.done), 32'd0);
        end
        load8(8'd9, 8'd9);
        run8(4'b0010, lat, bcnt);
        chk("abort_rerun_c",   32'(bus8.c), 32'd81);
        chk("abort_rerun_lat", 32'(lat),    32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor of the 3-bit two-operand ALU.
- Two operand registers are loaded by strobes, and an opcode is executed on a run strobe.
- The result is held in a registered accumulator output.
- Multiplication runs as a multi-cycle shift-add engine; all other ops complete in one cycle. Busy/done handshake is added for the sequencer above it.
- Sits between the operand switch/bus interface and the result display/accumulator consumer.

Parameters:
- WIDTH, 8, operand width in bits (minimum 2; WIDTH=3 reproduces legacy behaviour).
- CW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately on assertion.
- a  in  WIDTH  operand 1 data.
- b  in  WIDTH  operand 2 data.
- load1  in  1  capture a into operand register A.
- load2  in  1  capture b into operand register B.
- op_code  in  4  operation select (encoding below).
- run  in  1  start strobe; sampled each cycle.
- c  out  2*WIDTH  registered result accumulator.
- zero  out  1  registered flag: c == 0, updated together with c.
- err  out  1  registered flag: last run used an undefined opcode.
- busy  out  1  high while the multiplier is iterating.
- done  out  1  one-cycle pulse in the cycle c/zero/err take a new value.

Behaviour:
- Reset (reset=0, asynchronous): A, B, c, counter, multiplicand/partial registers = 0; zero=1; err=0; busy=0; done=0; FSM = IDLE. Release is synchronous to the next clk edge.
- Operand load:
  - On a clock edge in IDLE, load1=1 sets A<=a and load2=1 sets B<=b. Both strobes may be active in the same cycle.
  - Loads in MUL are ignored; A/B stay stable.
  - Load and run in the same cycle: run uses the pre-edge A/B. New values apply from the next run.
- op_code decode:
  - 0000 add: c = zero-extended A+B (WIDTH+1 bits).
  - 0001 XOR.
  - 0010 multiply (multi-cycle).
  - 0011 shift left: c = A<<B in the 2W field; B >= 2W gives 0.
  - 0100 shift right: c = A>>B; B >= WIDTH gives 0.
  - 0101 AND.
  - 0110 OR.
  - 0111 NAND: WIDTH bits.
  - 1000 NOR: WIDTH bits.
  - 1001 A<<1: WIDTH+1 bits.
  - 1010 A>>1.
  - Logic results are zero-extended to 2W.
  - 1011–1111 undefined: c=0, zero=1, err=1.
  - err is cleared by any subsequent defined op.
- FSM states are IDLE and MUL.
  - IDLE, run=1, op != 0010: next edge writes c/zero/err and pulses done. Stays IDLE, so latency is 1 cycle. Back-to-back runs each cycle are legal.
  - IDLE, run=1, op = 0010: next edge loads multiplicand=A (zero-extended to 2W), multiplier=B, partial=0, count=0, and enters MUL. busy=1 from that edge.
  - MUL, each cycle: if multiplier[0], partial += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count++.
  - After the WIDTH-th iteration: c <= final partial, zero updated, err=0, done pulses, busy=0, return to IDLE.
  - Total multiply latency is WIDTH+1 edges from the run edge to done.
- run while busy is ignored: not queued, no error.
- op_code is sampled only at the accepted run edge. Changes during MUL have no effect.
- c holds its value between runs. It is not cleared by load1/load2.
- Reset asserted mid-multiply aborts immediately. No done pulse; c = 0 after reset.
- No overflow is possible: 2W bits hold every defined result.

Decomposition:
- Shared package seq_alu_pkg holds:
  - opcode localparams OP_ADD … OP_SHR1 (4-bit);
  - the FSM state enum (IDLE, MUL).
- One sub-module: seq_alu_mul, the shift-add iteration engine.
  - Inputs: clk, reset, start, A, B.
  - Outputs: product, busy, valid.
  - Parametrised by WIDTH.
- Top level holds operand registers, single-cycle datapath mux, result/flag registers, done/err logic.

Test Plan:
- WIDTH=3: load a=5, b=2. op 0010 run → done after 4 edges, c=10. op 0110 run → done after 1 edge, c=7.
- WIDTH=8: A=255, B=255, op 0010 → busy high for 8 cycles, c=65025, zero=0, done one cycle only. A=200, B=100, op 0000 → c=300.
- WIDTH=8, shifts: A=0x81 op 1001 → c=0x102. A=0x81, B=3 op 0011 → c=0x408. A=0x81, B=9 op 0100 → c=0. A=1, B=16 op 0011 → c=0, zero=1.
- During multiply (A=7, B=6): pulse run with op 0000, and load1 with a=1, at cycle 3 → both ignored; c=42; A still 7 afterwards.
- op 1101 run → c=0, err=1, zero=1, done pulse. Next op 0101 with A=0xF0, B=0x3C → c=0x30, err=0.
- Multiply A=9, B=9 at WIDTH=8; assert reset at iteration 4 → outputs cleared asynchronously (c=0, zero=1, busy=0), no done. After release, run op 0010 again → c=81.
